// File: rtl/alu_arb.sv
// Two-requester sequencer in front of a shared 4-bit combinational ALU.
// One operation in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
module alu_arb #(
    parameter int W    = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [W-1:0]    req_a0,
    input  logic [W-1:0]    req_b0,
    input  logic [2:0]      req_ctrl0,
    input  logic [W-1:0]    req_a1,
    input  logic [W-1:0]    req_b1,
    input  logic [2:0]      req_ctrl1,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [W-1:0]    rsp_res,
    output logic            rsp_car,
    output logic            rsp_of,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [W-1:0]    alu_res,
    input  logic            alu_car,
    input  logic            alu_of,
    output logic            busy,
    output logic [CNTW-1:0] done_cnt0,
    output logic [CNTW-1:0] done_cnt1,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   gid;
    logic [1:0] grant;

    // Handshake: an operation transfers on a clock edge where req_valid[i] and
    // req_ready[i] are both high; a response transfers where rsp_valid[i] and
    // rsp_ready[i] are both high. Neither ready depends on the same-side valid
    // of the other requester except through the round-robin choice below.
    always_comb begin
        grant = 2'b00;
        if (rst_n && state == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign rsp_valid = (state == RESP) ? {gid, ~gid} : 2'b00;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gid        <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= 3'b000;
            rsp_res    <= '0;
            rsp_car    <= 1'b0;
            rsp_of     <= 1'b0;
            done_cnt0  <= '0;
            done_cnt1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        gid <= grant[1];
                        if (grant[1]) begin
                            alu_a    <= req_a1;
                            alu_b    <= req_b1;
                            alu_ctrl <= req_ctrl1;
                        end else begin
                            alu_a    <= req_a0;
                            alu_b    <= req_b0;
                            alu_ctrl <= req_ctrl0;
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable for a full cycle; sample the ALU.
                    rsp_res <= alu_res;
                    rsp_car <= alu_car;
                    rsp_of  <= alu_of;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gid]) begin
                        last_grant <= gid;
                        if (gid) done_cnt1 <= done_cnt1 + CNTW'(1);
                        else     done_cnt0 <= done_cnt0 + CNTW'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: external ALU modelled here, round-robin
// and counter behaviour predicted by a small model, random and directed ops.
module tb_alu_arb;
    localparam int W    = 4;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [W-1:0]    req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [2:0]      req_ctrl0 = '0, req_ctrl1 = '0;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready = 2'b00;
    logic [W-1:0]    rsp_res;
    logic            rsp_car, rsp_of;
    logic [W-1:0]    alu_a, alu_b, alu_res;
    logic [2:0]      alu_ctrl;
    logic            alu_car, alu_of;
    logic            busy;
    logic [CNTW-1:0] done_cnt0, done_cnt1;
    logic [1:0]      state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    bit last_m;
    int cnt_m[2];
    logic [5:0] exp_q[$];

    alu_arb #(.W(W), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_ctrl0(req_ctrl0),
        .req_a1(req_a1), .req_b1(req_b1), .req_ctrl1(req_ctrl1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_car(rsp_car), .rsp_of(rsp_of),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
        .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // External ALU: returns {of, car, res}
    function automatic logic [5:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] c);
        logic [4:0] s;
        logic [3:0] r;
        logic car, of;
        car = 1'b0; of = 1'b0; s = 5'd0; r = 4'd0;
        case (c)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b}; r = s[3:0]; car = s[4];
                of = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; car = s[4];
                of = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = {3'b000, a < b};
            default: r = {3'b000, a == b};
        endcase
        return {of, car, r};
    endfunction

    always_comb {alu_of, alu_car, alu_res} = alu_fn(alu_a, alu_b, alu_ctrl);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] c);
        if (r == 1) begin req_a1 = a; req_b1 = b; req_ctrl1 = c; end
        else        begin req_a0 = a; req_b0 = b; req_ctrl0 = c; end
    endtask

    task automatic hold_reset();
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        tick();
        rst_n = 1'b1;
        last_m = 1'b1; cnt_m[0] = 0; cnt_m[1] = 0;
        exp_q.delete();
        tick();
    endtask

    // Issues one op with no response stall; ok=0 if a bounded wait expires.
    task automatic op_fast(input int r, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] c, output bit ok, output logic [1:0] rv);
        int n;
        ok = 1'b0; rv = 2'b00;
        set_op(r, a, b, c);
        req_valid = (r == 1) ? 2'b10 : 2'b01;
        #1;
        n = 0;
        while (req_ready !== req_valid && n < 8) begin tick(); n++; end
        if (req_ready !== req_valid) begin req_valid = 2'b00; return; end
        tick();
        rsp_ready = req_valid;
        req_valid = 2'b00;
        n = 0;
        while (rsp_valid !== rsp_ready && n < 8) begin tick(); n++; end
        rv = rsp_valid;
        if (rsp_valid !== rsp_ready) begin rsp_ready = 2'b00; return; end
        tick();
        rsp_ready = 2'b00;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        @(posedge clk); @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: rsp_valid=%b busy=%b want 00/0", rsp_valid, busy);
        end
        n_cmp++;
        if (done_cnt0 !== 8'd0 || done_cnt1 !== 8'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", done_cnt0, done_cnt1);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_ctrl, rsp_res, rsp_car, rsp_of} !== 17'd0) begin
            n_err++; $display("FAIL reset_regs: alu=%h/%h/%h rsp=%h/%b/%b want zeros",
                              alu_a, alu_b, alu_ctrl, rsp_res, rsp_car, rsp_of);
        end
        req_valid = 2'b00; rsp_ready = 2'b00;
        rst_n = 1'b1;
        last_m = 1'b1; cnt_m[0] = 0; cnt_m[1] = 0;
        tick();
    endtask

    task automatic test_basic();
        set_op(0, 4'd3, 4'd4, 3'd0);
        req_valid = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL basic_ready: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        n_cmp++;
        if ({alu_a, alu_b, alu_ctrl} !== {4'd3, 4'd4, 3'd0} || busy !== 1'b1 || rsp_valid !== 2'b00) begin
            n_err++; $display("FAIL basic_exec: alu=%h/%h/%h busy=%b rsp_valid=%b want 3/4/0 1 00",
                              alu_a, alu_b, alu_ctrl, busy, rsp_valid);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 2'b01 || {rsp_of, rsp_car, rsp_res} !== {1'b0, 1'b0, 4'd7}) begin
            n_err++; $display("FAIL basic_rsp: valid=%b res=%0d car=%b of=%b want 01 7 0 0",
                              rsp_valid, rsp_res, rsp_car, rsp_of);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        cnt_m[0]++; last_m = 1'b0;
        n_cmp++;
        if (done_cnt0 !== 8'd1 || rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_res !== 4'd7) begin
            n_err++; $display("FAIL basic_done: cnt0=%0d valid=%b busy=%b res=%0d want 1 00 0 7",
                              done_cnt0, rsp_valid, busy, rsp_res);
        end
    endtask

    task automatic test_req1();
        bit ok;
        logic [1:0] rv;
        op_fast(1, 4'd7, 4'd1, 3'd0, ok, rv);
        cnt_m[1]++; last_m = 1'b1;
        n_cmp++;
        if (!ok || rv !== 2'b10 || {rsp_of, rsp_car, rsp_res} !== {1'b1, 1'b0, 4'd8}) begin
            n_err++; $display("FAIL req1_add: ok=%b valid=%b res=%0d car=%b of=%b want 10 8 0 1",
                              ok, rv, rsp_res, rsp_car, rsp_of);
        end
        op_fast(1, 4'd5, 4'd3, 3'd1, ok, rv);
        cnt_m[1]++;
        n_cmp++;
        if (!ok || rv !== 2'b10 || {rsp_of, rsp_car, rsp_res} !== {1'b0, 1'b1, 4'd2}) begin
            n_err++; $display("FAIL req1_sub: ok=%b valid=%b res=%0d car=%b of=%b want 10 2 1 0",
                              ok, rv, rsp_res, rsp_car, rsp_of);
        end
        n_cmp++;
        if (done_cnt1 !== CNTW'(cnt_m[1])) begin
            n_err++; $display("FAIL req1_cnt: got %0d want %0d", done_cnt1, cnt_m[1]);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        logic [5:0] e;
        hold_reset();
        rsp_ready = 2'b11;
        set_op(0, 4'($urandom), 4'($urandom), 3'($urandom));
        set_op(1, 4'($urandom), 4'($urandom), 3'($urandom));
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            want = last_m ? 2'b01 : 2'b10;
            e = want[1] ? alu_fn(req_a1, req_b1, req_ctrl1) : alu_fn(req_a0, req_b0, req_ctrl0);
            n_cmp++;
            if (req_ready !== want) begin
                n_err++; $display("FAIL rr_grant op%0d: got %b want %b", i, req_ready, want);
            end
            tick();
            // Operand changes while busy must not reach the response.
            set_op(0, 4'($urandom), 4'($urandom), 3'($urandom));
            set_op(1, 4'($urandom), 4'($urandom), 3'($urandom));
            tick();
            n_cmp++;
            if (rsp_valid !== want || {rsp_of, rsp_car, rsp_res} !== e) begin
                n_err++; $display("FAIL rr_rsp op%0d: valid=%b bits=%h want %b %h",
                                  i, rsp_valid, {rsp_of, rsp_car, rsp_res}, want, e);
            end
            last_m = want[1]; cnt_m[want[1]]++;
            tick();
        end
        req_valid = 2'b00; rsp_ready = 2'b00;
        n_cmp++;
        if (done_cnt0 !== 8'd2 || done_cnt1 !== 8'd2) begin
            n_err++; $display("FAIL rr_cnt: got %0d/%0d want 2/2", done_cnt0, done_cnt1);
        end
    endtask

    task automatic test_stall();
        set_op(0, 4'd9, 4'd6, 3'd5);
        set_op(1, 4'd2, 4'd2, 3'd7);
        req_valid = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL stall_grant: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            rsp_ready = (i % 2 == 1) ? 2'b10 : 2'b00;
            #1;
            n_cmp++;
            if (rsp_valid !== 2'b01 || {rsp_of, rsp_car, rsp_res} !== 6'h0F ||
                req_ready !== 2'b00 || busy !== 1'b1) begin
                n_err++; $display("FAIL stall_hold c%0d: valid=%b bits=%h ready=%b busy=%b want 01 0f 00 1",
                                  i, rsp_valid, {rsp_of, rsp_car, rsp_res}, req_ready, busy);
            end
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        cnt_m[0]++; last_m = 1'b0;
        n_cmp++;
        if (req_ready !== 2'b10 || done_cnt0 !== CNTW'(cnt_m[0])) begin
            n_err++; $display("FAIL stall_next: ready=%b cnt0=%0d want 10 %0d", req_ready, done_cnt0, cnt_m[0]);
        end
        tick();
        req_valid = 2'b00;
        tick();
        n_cmp++;
        if (rsp_valid !== 2'b10 || {rsp_of, rsp_car, rsp_res} !== 6'h01) begin
            n_err++; $display("FAIL stall_waiter: valid=%b bits=%h want 10 01", rsp_valid, {rsp_of, rsp_car, rsp_res});
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        cnt_m[1]++; last_m = 1'b1;
    endtask

    task automatic test_random();
        bit has[2];
        logic [3:0] pa[2], pb[2];
        logic [2:0] pc[2];
        logic [1:0] want;
        logic [5:0] e;
        int g, ops, guard, stall;
        has[0] = 0; has[1] = 0; ops = 0; guard = 0;
        while (ops < 24 && guard < 400) begin
            guard++;
            for (int r = 0; r < 2; r++) begin
                if (!has[r] && $urandom_range(0, 2) != 0) begin
                    has[r] = 1;
                    pa[r] = 4'($urandom); pb[r] = 4'($urandom); pc[r] = 3'($urandom);
                    set_op(r, pa[r], pb[r], pc[r]);
                end
            end
            if (!has[0] && !has[1]) begin tick(); continue; end
            req_valid = {has[1], has[0]};
            #1;
            if (has[0] && has[1]) want = last_m ? 2'b01 : 2'b10;
            else                  want = {has[1], has[0]};
            n_cmp++;
            if (req_ready !== want) begin
                n_err++; $display("FAIL rand_grant op%0d: got %b want %b", ops, req_ready, want);
            end
            g = want[1] ? 1 : 0;
            exp_q.push_back(alu_fn(pa[g], pb[g], pc[g]));
            has[g] = 0;
            tick();
            req_valid = {has[1], has[0]};
            tick();
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                rsp_ready = 2'($urandom_range(0, 3)) & ~want;
                #1;
                n_cmp++;
                if (rsp_valid !== want || req_ready !== 2'b00) begin
                    n_err++; $display("FAIL rand_stall op%0d: valid=%b ready=%b want %b 00",
                                      ops, rsp_valid, req_ready, want);
                end
                tick();
            end
            rsp_ready = want | (2'($urandom_range(0, 3)) & ~want);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (rsp_valid !== want || {rsp_of, rsp_car, rsp_res} !== e) begin
                n_err++; $display("FAIL rand_rsp op%0d: valid=%b bits=%h want %b %h",
                                  ops, rsp_valid, {rsp_of, rsp_car, rsp_res}, want, e);
            end
            tick();
            rsp_ready = 2'b00;
            last_m = want[1]; cnt_m[g]++; ops++;
        end
        req_valid = 2'b00;
        n_cmp++;
        if (ops != 24 || done_cnt0 !== CNTW'(cnt_m[0]) || done_cnt1 !== CNTW'(cnt_m[1])) begin
            n_err++; $display("FAIL rand_cnt: ops=%0d cnt=%0d/%0d want 24 %0d/%0d",
                              ops, done_cnt0, done_cnt1, cnt_m[0], cnt_m[1]);
        end
    endtask

    task automatic test_reset_mid();
        set_op(0, 4'd1, 4'd2, 3'd0);
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_exec: busy=%b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || done_cnt0 !== 8'd0 || done_cnt1 !== 8'd0) begin
            n_err++; $display("FAIL rmid_clear: valid=%b busy=%b cnt=%0d/%0d want 00 0 0/0",
                              rsp_valid, busy, done_cnt0, done_cnt1);
        end
        last_m = 1'b1; cnt_m[0] = 0; cnt_m[1] = 0;
        tick(); tick();
        rst_n = 1'b1;
        n_cmp++;
        if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rmid_norsp: valid=%b want 00", rsp_valid); end
        set_op(0, 4'd6, 4'd5, 3'd6);
        set_op(1, 4'd3, 4'd3, 3'd7);
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL rmid_first: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        tick();
        n_cmp++;
        if (rsp_valid !== 2'b01 || {rsp_of, rsp_car, rsp_res} !== 6'h00) begin
            n_err++; $display("FAIL rmid_rsp: valid=%b bits=%h want 01 00", rsp_valid, {rsp_of, rsp_car, rsp_res});
        end
        tick();
        rsp_ready = 2'b00;
        cnt_m[0]++; last_m = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [1:0] rv;
        hold_reset();
        for (int i = 0; i < 256; i++) begin
            op_fast(0, 4'($urandom), 4'($urandom), 3'($urandom), ok, rv);
            if (!ok) begin
                n_cmp++; n_err++;
                $display("FAIL wrap_op%0d: handshake timed out, rsp_valid=%b", i, rv);
                break;
            end
            cnt_m[0]++; last_m = 1'b0;
            if (i == 254) begin
                n_cmp++;
                if (done_cnt0 !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d want 255", done_cnt0); end
            end
        end
        n_cmp++;
        if (done_cnt0 !== 8'd0 || done_cnt0 !== CNTW'(cnt_m[0]) || done_cnt1 !== 8'd0) begin
            n_err++; $display("FAIL wrap_zero: cnt=%0d/%0d want 0/0", done_cnt0, done_cnt1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req1();
        test_round_robin();
        test_stall();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
